// File: rtl/calc_operand_entry.sv
// Operand entry front end: synchronizes and debounces the Confirm/Back buttons,
// sequences A, B and the operator from the switches, and offers the triple to the core.
module calc_operand_entry #(
   parameter int unsigned DEBOUNCE_CYCLES = 2500000,
   parameter int unsigned CNT_W           = 22
) (
   input  logic        board_clk,
   input  logic        Reset,
   input  logic [15:0] In,
   input  logic        BtnConfirm,
   input  logic        BtnBack,
   input  logic        operands_ready,
   output logic [15:0] A,
   output logic [15:0] B,
   output logic [1:0]  Op,
   output logic        operands_valid,
   output logic [1:0]  stage,
   output logic        confirm_pulse
);

   typedef enum logic [1:0] {
      GET_A  = 2'b00,
      GET_B  = 2'b01,
      GET_OP = 2'b10,
      HOLD   = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Button index 0 is Confirm, index 1 is Back.
   logic [1:0]            sync1_q, sync1_d;
   logic [1:0]            sync2_q, sync2_d;
   logic [1:0]            deb_q, deb_d;
   logic [1:0]            deb_dly_q, deb_dly_d;
   logic [1:0]            arm_q, arm_d;
   logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0][CNT_W-1:0] rel_cnt_q, rel_cnt_d;
   logic [1:0]            pulse;

   state_t      state_q, state_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [1:0]  op_q, op_d;
   logic        valid_q, valid_d;
   logic        cp, bp;

   // A button only becomes armed after its synchronized level has been seen low
   // for a full debounce window, so a button held through reset cannot pulse.
   always_comb begin
      sync1_d   = {BtnBack, BtnConfirm};
      sync2_d   = sync1_q;
      deb_dly_d = deb_q;
      deb_d     = deb_q;
      arm_d     = arm_q;
      cnt_d     = '0;
      rel_cnt_d = '0;
      pulse     = '0;
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_LAST) deb_d[i] = sync2_q[i];
            else                      cnt_d[i] = cnt_q[i] + CNT_ONE;
         end
         if (!arm_q[i] && !sync2_q[i]) begin
            if (rel_cnt_q[i] == CNT_LAST) arm_d[i]     = 1'b1;
            else                          rel_cnt_d[i] = rel_cnt_q[i] + CNT_ONE;
         end
         pulse[i] = deb_q[i] & ~deb_dly_q[i] & arm_q[i];
      end
   end

   assign cp = pulse[0];
   assign bp = pulse[1];

   // Handshake: operands_valid is a flop that rises on entry to HOLD and holds
   // A/B/Op steady until a cycle with operands_ready=1; it falls on the next
   // edge. operands_ready has no combinational path to operands_valid.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      valid_d = valid_q;
      case (state_q)
         GET_A: begin
            if (cp) begin
               a_d     = In;
               state_d = GET_B;
            end
         end
         GET_B: begin
            if (bp) begin
               state_d = GET_A;
            end else if (cp) begin
               b_d     = In;
               state_d = GET_OP;
            end
         end
         GET_OP: begin
            if (bp) begin
               state_d = GET_B;
            end else if (cp) begin
               op_d    = In[1:0];
               valid_d = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (operands_ready) begin
               valid_d = 1'b0;
               state_d = GET_A;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = GET_A;
         end
      endcase
   end

   always_ff @(posedge board_clk or posedge Reset) begin
      if (Reset) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         deb_q     <= '0;
         deb_dly_q <= '0;
         arm_q     <= '0;
         cnt_q     <= '0;
         rel_cnt_q <= '0;
         state_q   <= GET_A;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         valid_q   <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         deb_q     <= deb_d;
         deb_dly_q <= deb_dly_d;
         arm_q     <= arm_d;
         cnt_q     <= cnt_d;
         rel_cnt_q <= rel_cnt_d;
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         op_q      <= op_d;
         valid_q   <= valid_d;
      end
   end

   assign A              = a_q;
   assign B              = b_q;
   assign Op             = op_q;
   assign operands_valid = valid_q;
   assign stage          = state_q;
   assign confirm_pulse  = cp;

endmodule
